// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: shared register-address constants and port-select type
package regfile_wb_arbiter_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS = 32;
    localparam logic [NUM_REGS-1:0] REG_ONE = 1;
    typedef enum logic [1:0] {SEL_NONE, SEL_A, SEL_B} sel_t;
endpackage

// File: rtl/regfile_wb_arbiter_wb_scoreboard.sv
// wb_scoreboard: busy vector of destinations pending on port B, decode hazard and sticky error
module wb_scoreboard
    import regfile_wb_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  a_grant,
    input  logic [REG_ADDR_W-1:0] a_rd,
    input  logic                  b_grant,
    input  logic [REG_ADDR_W-1:0] b_rd,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic                  byp1,
    input  logic                  byp2,
    output logic                  hazard,
    output logic [NUM_REGS-1:0]   busy,
    output logic                  err
);
    logic [NUM_REGS-1:0] set_v, clr_v, busy_nxt;
    logic src1, src2, iss_hit, err_ev;
    // set is ORed in after the clear so a same-cycle reissue keeps the register busy
    always_comb begin
        set_v = (issue_valid && issue_rd != '0) ? REG_ONE << issue_rd : '0;
        clr_v = b_grant ? REG_ONE << b_rd : '0;
        busy_nxt = ((busy & ~clr_v) | set_v) & ~REG_ONE;
        src1 = rs1 != '0 && busy[rs1] && !byp1;
        src2 = rs2 != '0 && busy[rs2] && !byp2;
        iss_hit = issue_valid && issue_rd != '0 && (issue_rd == rs1 || issue_rd == rs2);
        hazard = src1 || src2 || iss_hit;
        err_ev = (|(set_v & busy & ~clr_v)) || (b_grant && b_rd != '0 && !busy[b_rd]) || (a_grant && busy[a_rd]);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
            err <= 1'b0;
        end else begin
            busy <= busy_nxt;
            err <= err | err_ev;
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin share of the RegFile write port between pipeline (A) and long-latency (B) writeback.
// Defining RF_WB_BYPASS_EN adds fwd1_en/fwd2_en/fwd_data forwarding of the B result to decode.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int n = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    input  logic [REG_ADDR_W-1:0] a_rd,
    input  logic [n-1:0]          a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [REG_ADDR_W-1:0] b_rd,
    input  logic [n-1:0]          b_data,
    output logic                  b_ready,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic                  hazard,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_rd,
    output logic [n-1:0]          rf_wdata,
    output logic [NUM_REGS-1:0]   busy,
    output logic                  err
`ifdef RF_WB_BYPASS_EN
    ,
    output logic                  fwd1_en,
    output logic                  fwd2_en,
    output logic [n-1:0]          fwd_data
`endif
);
    sel_t sel;
    logic last_b, byp1, byp2;
    // on contention the port not served last wins; last_b resets to 0 so B goes first
    always_comb sel = (a_valid && b_valid) ? (last_b ? SEL_A : SEL_B) : a_valid ? SEL_A : b_valid ? SEL_B : SEL_NONE;
    assign a_ready = sel == SEL_A;
    assign b_ready = sel == SEL_B;
    assign rf_rd = a_ready ? a_rd : b_ready ? b_rd : '0;
    assign rf_wdata = a_ready ? a_data : b_ready ? b_data : '0;
    assign rf_we = (a_ready || b_ready) && rf_rd != '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_b <= 1'b0;
        else if (sel != SEL_NONE) last_b <= sel == SEL_B;
    end
`ifdef RF_WB_BYPASS_EN
    assign fwd1_en = b_ready && b_rd != '0 && b_rd == rs1;
    assign fwd2_en = b_ready && b_rd != '0 && b_rd == rs2;
    assign fwd_data = (fwd1_en || fwd2_en) ? b_data : '0;
    assign byp1 = fwd1_en;
    assign byp2 = fwd2_en;
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif
    wb_scoreboard u_sb (
        .clk(clk),
        .rst(rst),
        .issue_valid(issue_valid),
        .issue_rd(issue_rd),
        .a_grant(a_ready),
        .a_rd(a_rd),
        .b_grant(b_ready),
        .b_rd(b_rd),
        .rs1(rs1),
        .rs2(rs2),
        .byp1(byp1),
        .byp2(byp2),
        .hazard(hazard),
        .busy(busy),
        .err(err)
    );
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed vector table plus hand sequences for contention, errors and mid-cycle reset
module tb_regfile_wb_arbiter;
    logic clk = 0, rst = 1;
    logic a_valid, b_valid, issue_valid, a_ready, b_ready, hazard, rf_we, err;
    logic [4:0] a_rd, b_rd, issue_rd, rs1, rs2, rf_rd;
    logic [31:0] a_data, b_data, rf_wdata, busy;
`ifdef RF_WB_BYPASS_EN
    logic fwd1_en, fwd2_en;
    logic [31:0] fwd_data;
`endif
    int pass = 0, total = 0, wcount = 0;

    regfile_wb_arbiter #(.n(32)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2),
        .hazard(hazard), .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .busy(busy), .err(err)
`ifdef RF_WB_BYPASS_EN
        , .fwd1_en(fwd1_en), .fwd2_en(fwd2_en), .fwd_data(fwd_data)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (rf_we && rf_rd == 5'd3) wcount++;

    typedef struct {
        logic av; logic [4:0] ard; logic [31:0] ad;
        logic bv; logic [4:0] brd; logic [31:0] bd;
        logic iv; logic [4:0] ird; logic [4:0] r1; logic [4:0] r2;
        logic ar; logic br; logic we; logic [4:0] wrd; logic [31:0] wd;
        logic hz; logic [31:0] bsy; logic er;
    } vec_t;
    vec_t v[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else pass++;
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic bv, input logic [4:0] brd, input logic [31:0] bd,
                         input logic iv, input logic [4:0] ird, input logic [4:0] r1, input logic [4:0] r2);
        a_valid = av; a_rd = ard; a_data = ad;
        b_valid = bv; b_rd = brd; b_data = bd;
        issue_valid = iv; issue_rd = ird; rs1 = r1; rs2 = r2;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        idle_cycle();
        rst = 1;
        @(negedge clk);
        rst = 0;
        #1;
    endtask

    logic hz4;
    logic [1:0] exp_grant[4];

    initial begin
`ifdef RF_WB_BYPASS_EN
        hz4 = 0;
`else
        hz4 = 1;
`endif
        //        av ard ad      bv brd bd        iv ird r1 r2   ar br we wrd wd       hz  bsy       er
        v[0]  = '{0, 0, 0,       0, 0, 0,         0, 0, 0, 0,    0, 0, 0, 0, 0,        0,  0,        0};
        v[1]  = '{1, 5, 32'hAA,  0, 0, 0,         0, 0, 0, 0,    1, 0, 1, 5, 32'hAA,   0,  0,        0};
        v[2]  = '{0, 0, 0,       0, 0, 0,         1, 7, 0, 0,    0, 0, 0, 0, 0,        0,  0,        0};
        v[3]  = '{0, 0, 0,       0, 0, 0,         0, 0, 7, 0,    0, 0, 0, 0, 0,        1,  32'h80,   0};
        v[4]  = '{0, 0, 0,       1, 7, 32'h1234,  0, 0, 7, 0,    0, 1, 1, 7, 32'h1234, hz4, 32'h80,  0};
        v[5]  = '{0, 0, 0,       0, 0, 0,         0, 0, 7, 0,    0, 0, 0, 0, 0,        0,  0,        0};
        v[6]  = '{0, 0, 0,       0, 0, 0,         1, 9, 0, 9,    0, 0, 0, 0, 0,        1,  0,        0};
        v[7]  = '{1, 0, 32'h55,  0, 0, 0,         0, 0, 0, 0,    1, 0, 0, 0, 32'h55,   0,  32'h200,  0};
        v[8]  = '{0, 0, 0,       1, 9, 32'h99,    1, 9, 0, 0,    0, 1, 1, 9, 32'h99,   0,  32'h200,  0};
        v[9]  = '{0, 0, 0,       0, 0, 0,         0, 0, 0, 0,    0, 0, 0, 0, 0,        0,  32'h200,  0};
        v[10] = '{0, 0, 0,       1, 9, 32'h77,    0, 0, 0, 0,    0, 1, 1, 9, 32'h77,   0,  32'h200,  0};
        v[11] = '{0, 0, 0,       0, 0, 0,         1, 3, 0, 0,    0, 0, 0, 0, 0,        0,  0,        0};
        v[12] = '{0, 0, 0,       0, 0, 0,         1, 3, 0, 0,    0, 0, 0, 0, 0,        0,  32'h8,    0};
        v[13] = '{0, 0, 0,       0, 0, 0,         0, 0, 0, 0,    0, 0, 0, 0, 0,        0,  32'h8,    1};
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(v[i].av, v[i].ard, v[i].ad, v[i].bv, v[i].brd, v[i].bd, v[i].iv, v[i].ird, v[i].r1, v[i].r2);
            #1;
            chk($sformatf("v%0d a_ready", i), 32'(a_ready), 32'(v[i].ar));
            chk($sformatf("v%0d b_ready", i), 32'(b_ready), 32'(v[i].br));
            chk($sformatf("v%0d rf_we", i), 32'(rf_we), 32'(v[i].we));
            chk($sformatf("v%0d rf_rd", i), 32'(rf_rd), 32'(v[i].wrd));
            chk($sformatf("v%0d rf_wdata", i), rf_wdata, v[i].wd);
            chk($sformatf("v%0d hazard", i), 32'(hazard), 32'(v[i].hz));
            chk($sformatf("v%0d busy", i), busy, v[i].bsy);
            chk($sformatf("v%0d err", i), 32'(err), 32'(v[i].er));
`ifdef RF_WB_BYPASS_EN
            if (i == 4) begin
                chk("v4 fwd1_en", 32'(fwd1_en), 32'd1);
                chk("v4 fwd2_en", 32'(fwd2_en), 32'd0);
                chk("v4 fwd_data", fwd_data, 32'h1234);
            end
`endif
        end

        // err stays set while idle, clears only on reset
        for (int i = 0; i < 3; i++) begin
            idle_cycle();
            #1 chk($sformatf("err sticky %0d", i), 32'(err), 32'd1);
        end
        do_reset();
        chk("err after reset", 32'(err), 32'd0);
        chk("busy after reset", busy, 32'd0);

        // B writeback to a register that was never issued
        @(negedge clk);
        drive(0, 0, 0, 1, 4, 32'h44, 0, 0, 0, 0);
        #1 chk("b rd4 ready", 32'(b_ready), 32'd1);
        idle_cycle();
        #1 chk("b non-busy err", 32'(err), 32'd1);
        do_reset();

        // A writes a register still pending on B
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 1, 6, 0, 0);
        @(negedge clk);
        drive(1, 6, 32'h66, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("waw a_ready", 32'(a_ready), 32'd1);
        chk("waw err before edge", 32'(err), 32'd0);
        idle_cycle();
        #1 chk("waw err", 32'(err), 32'd1);
        chk("waw busy kept", busy, 32'h40);
        do_reset();

        // contention from reset: B,A,B,A
        exp_grant = '{2'b01, 2'b10, 2'b01, 2'b10};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1, 1, 32'hA1, 1, 0, 32'hB0, 0, 0, 0, 0);
            #1;
            chk($sformatf("rr%0d grant {a,b}", i), 32'({a_ready, b_ready}), 32'(exp_grant[i]));
        end
        idle_cycle();
        #1 chk("rr err", 32'(err), 32'd0);

        // asynchronous reset between edges with busy[3..6] set and B pending
        for (int r = 3; r <= 7; r++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 0, 1, 5'(r), 0, 0);
        end
        @(negedge clk);
        drive(0, 0, 0, 1, 7, 32'h77, 0, 0, 0, 0);
        #1 chk("mid b7 ready", 32'(b_ready), 32'd1);
        @(negedge clk);
        drive(1, 10, 32'hA0, 1, 3, 32'h33, 0, 0, 0, 0);
        wcount = 0;
        #1;
        chk("mid busy before rst", busy, 32'h78);
        chk("mid a wins before rst", 32'({a_ready, b_ready}), 32'b10);
        #1 rst = 1;
        #1;
        chk("mid busy in rst", busy, 32'd0);
        chk("mid b wins after rst", 32'({a_ready, b_ready}), 32'b01);
        rst = 0;
        @(negedge clk);
        #1 chk("mid a after b", 32'(a_ready), 32'd1);
        drive(1, 10, 32'hA0, 0, 0, 0, 0, 0, 0, 0);
        idle_cycle();
        idle_cycle();
        #1 chk("mid rd3 writes", 32'(wcount), 32'd1);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
